// File: rtl/fp_to_int_conv.sv
// Three-stage IEEE-754 single-precision to signed 32-bit integer converter.
// Stages: unpack/classify, align shift, round/negate/saturate; all stages advance together.
module fp_to_int_conv #(
  parameter int RNE    = 0,
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        out_invalid,
  output logic        out_inexact
);

  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_HALF   = 3'd1,
    CLS_SMALL  = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_e;

  logic              adv_s;
  logic [STAGES-1:0] vld_r;

  logic [7:0]        exp_s;
  logic [22:0]       frac_s;
  cls_e              cls_s;

  logic              s1_sign_r;
  logic [23:0]       s1_man_r;
  logic signed [8:0] s1_e_r;
  cls_e              s1_cls_r;
  logic              s1_frac_nz_r;
  logic              s1_any_nz_r;
  logic              s1_min_r;

  logic [8:0]        lsh_s;
  logic [8:0]        rsh_s;
  logic [31:0]       lft_s;
  logic [47:0]       ext_s;
  logic [31:0]       mag_s;
  logic              g_s;
  logic              st_s;
  logic              ovf_s;

  logic              s2_sign_r;
  logic [31:0]       s2_mag_r;
  logic              s2_g_r;
  logic              s2_st_r;
  logic              s2_nan_r;
  logic              s2_inf_r;
  logic              s2_ovf_r;

  logic              rne_s;
  logic              inc_s;
  logic [31:0]       mag_rnd_s;
  logic [31:0]       z_s;
  logic              inv_s;
  logic              inx_s;

  assign adv_s     = out_ready | ~vld_r[STAGES-1];
  assign in_ready  = adv_s;
  assign out_valid = vld_r[STAGES-1];

  assign exp_s  = in_a[30:23];
  assign frac_s = in_a[22:0];

  // Classify the incoming float by its biased exponent and fraction.
  always_comb begin
    cls_s = CLS_NORMAL;
    if (exp_s == 8'd255) begin
      if (frac_s != 23'd0) begin
        cls_s = CLS_NAN;
      end else begin
        cls_s = CLS_INF;
      end
    end else if (exp_s < 8'd126) begin
      cls_s = CLS_SMALL;
    end else if (exp_s == 8'd126) begin
      cls_s = CLS_HALF;
    end else begin
      cls_s = CLS_NORMAL;
    end
  end

  // Stage valid bits; a bubble enters as a zero and only moves when the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= {STAGES{1'b0}};
    end else if (adv_s) begin
      vld_r <= {vld_r[STAGES-2:0], in_valid};
    end
  end

  // Stage 1 registers: unpacked fields, unbiased exponent and class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign_r    <= 1'b0;
      s1_man_r     <= 24'd0;
      s1_e_r       <= 9'sd0;
      s1_cls_r     <= CLS_SMALL;
      s1_frac_nz_r <= 1'b0;
      s1_any_nz_r  <= 1'b0;
      s1_min_r     <= 1'b0;
    end else if (adv_s) begin
      s1_sign_r    <= in_a[31];
      s1_man_r     <= {exp_s != 8'd0, frac_s};
      s1_e_r       <= $signed({1'b0, exp_s}) - 9'sd127;
      s1_cls_r     <= cls_s;
      s1_frac_nz_r <= (frac_s != 23'd0);
      s1_any_nz_r  <= (in_a[30:0] != 31'd0);
      s1_min_r     <= (in_a == 32'hCF00_0000);
    end
  end

  // Shift amounts are only meaningful inside their own exponent window.
  assign lsh_s = s1_e_r - 9'sd23;
  assign rsh_s = 9'sd23 - s1_e_r;
  assign lft_s = {8'd0, s1_man_r} << lsh_s;
  assign ext_s = {s1_man_r, 24'd0} >> rsh_s;

  // Align the mantissa to an integer magnitude and collect guard/sticky bits.
  always_comb begin
    mag_s = 32'd0;
    g_s   = 1'b0;
    st_s  = 1'b0;
    ovf_s = 1'b0;
    case (s1_cls_r)
      CLS_NORMAL: begin
        if ((s1_e_r >= 9'sd31) && !s1_min_r) begin
          ovf_s = 1'b1;
        end else if (s1_e_r >= 9'sd23) begin
          mag_s = lft_s;
        end else begin
          mag_s = {8'd0, ext_s[47:24]};
          g_s   = ext_s[23];
          st_s  = |ext_s[22:0];
        end
      end
      CLS_HALF: begin
        g_s  = 1'b1;
        st_s = s1_frac_nz_r;
      end
      CLS_SMALL: begin
        st_s = s1_any_nz_r;
      end
      default: begin
        mag_s = 32'd0;
      end
    endcase
  end

  // Stage 2 registers: magnitude, rounding bits and exception markers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign_r <= 1'b0;
      s2_mag_r  <= 32'd0;
      s2_g_r    <= 1'b0;
      s2_st_r   <= 1'b0;
      s2_nan_r  <= 1'b0;
      s2_inf_r  <= 1'b0;
      s2_ovf_r  <= 1'b0;
    end else if (adv_s) begin
      s2_sign_r <= s1_sign_r;
      s2_mag_r  <= mag_s;
      s2_g_r    <= g_s;
      s2_st_r   <= st_s;
      s2_nan_r  <= (s1_cls_r == CLS_NAN);
      s2_inf_r  <= (s1_cls_r == CLS_INF);
      s2_ovf_r  <= ovf_s;
    end
  end

  // Rounding increment cannot carry out: in-range rounded values stay below 2^24.
  assign rne_s     = (RNE != 0);
  assign inc_s     = rne_s & s2_g_r & (s2_st_r | s2_mag_r[0]);
  assign mag_rnd_s = s2_mag_r + {31'd0, inc_s};

  // Apply sign, then override with saturated codes for NaN, infinity and overflow.
  always_comb begin
    z_s   = s2_sign_r ? (32'd0 - mag_rnd_s) : mag_rnd_s;
    inv_s = 1'b0;
    inx_s = 1'b0;
    if (s2_nan_r) begin
      z_s   = 32'h8000_0000;
      inv_s = 1'b1;
    end else if (s2_inf_r || s2_ovf_r) begin
      z_s   = s2_sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
      inv_s = 1'b1;
    end else begin
      inx_s = s2_g_r | s2_st_r;
    end
  end

  // Output registers; bubbles present zeros, backpressure freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_z       <= 32'd0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else if (adv_s) begin
      out_z       <= vld_r[STAGES-2] ? z_s   : 32'd0;
      out_invalid <= vld_r[STAGES-2] ? inv_s : 1'b0;
      out_inexact <= vld_r[STAGES-2] ? inx_s : 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_to_int_conv.sv
// Scoreboard bench: one truncating and one round-to-nearest converter share a stimulus
// stream; expectations come from a real-arithmetic model or from hand-derived constants.
module tb_fp_to_int_conv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_z0, out_z1;
  logic        out_invalid0, out_invalid1;
  logic        out_inexact0, out_inexact1;

  int errors = 0;
  int checks = 0;

  logic [33:0] q0[$];
  logic [33:0] q1[$];

  logic        smp_rdy;
  logic        smp_ov;
  logic [31:0] smp_z;

  fp_to_int_conv #(.RNE(0), .STAGES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a),
    .out_valid(out_valid0), .out_ready(out_ready), .out_z(out_z0),
    .out_invalid(out_invalid0), .out_inexact(out_inexact0)
  );

  fp_to_int_conv #(.RNE(1), .STAGES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a),
    .out_valid(out_valid1), .out_ready(out_ready), .out_z(out_z1),
    .out_invalid(out_invalid1), .out_inexact(out_inexact1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value-level reference: exact real value, then truncate or round to nearest-even.
  function automatic logic [33:0] model(input logic [31:0] a, input bit rne);
    bit     sgn;
    int     e;
    int     f;
    real    v, fl, fr;
    longint ip;
    logic [31:0] z;
    sgn = a[31];
    e   = {24'd0, a[30:23]};
    f   = {9'd0, a[22:0]};
    if (e == 255) begin
      if (f != 0) return {32'h8000_0000, 1'b1, 1'b0};
      return {(sgn ? 32'h8000_0000 : 32'h7FFF_FFFF), 1'b1, 1'b0};
    end
    if (e == 0) v = real'(f) * (2.0 ** real'(-149));
    else        v = (8388608.0 + real'(f)) * (2.0 ** real'(e - 150));
    if (sgn ? (v > 2147483648.0) : (v >= 2147483648.0))
      return {(sgn ? 32'h8000_0000 : 32'h7FFF_FFFF), 1'b1, 1'b0};
    fl = $floor(v);
    fr = v - fl;
    ip = longint'(fl);
    if (rne && ((fr > 0.5) || ((fr == 0.5) && ip[0]))) ip = ip + 1;
    z = sgn ? 32'(-ip) : 32'(ip);
    return {z, 1'b0, (fr != 0.0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic mon(input int id, input logic [33:0] got);
    logic [33:0] exp;
    checks++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_out%0d: got z=%h inv=%b inx=%b with nothing expected",
               id, got[33:2], got[1], got[0]);
    end else begin
      exp = (id == 0) ? q0.pop_front() : q1.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL result%0d: got z=%h inv=%b inx=%b expected z=%h inv=%b inx=%b",
                 id, got[33:2], got[1], got[0], exp[33:2], exp[1], exp[0]);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer of either converter.
  always @(negedge clk) begin
    if (rst_n && out_ready && out_valid0) mon(0, {out_z0, out_invalid0, out_inexact0});
    if (rst_n && out_ready && out_valid1) mon(1, {out_z1, out_invalid1, out_inexact1});
  end

  // One cycle: drive at posedge+1, sample at negedge, push expectation if accepted.
  task automatic tick(input logic v, input logic [31:0] a, input logic r, input bit known,
                      input logic [33:0] e0, input logic [33:0] e1, output logic acc);
    in_valid  = v;
    in_a      = a;
    out_ready = r;
    @(negedge clk);
    smp_rdy = in_ready0;
    smp_ov  = out_valid0;
    smp_z   = out_z0;
    acc     = v & in_ready0;
    if (acc) begin
      if (known) begin
        q0.push_back(e0);
        q1.push_back(e1);
      end else begin
        q0.push_back(model(a, 1'b0));
        q1.push_back(model(a, 1'b1));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_known(input logic [31:0] a, input logic [33:0] e0, input logic [33:0] e1);
    logic acc;
    tick(1'b1, a, 1'b1, 1'b1, e0, e1, acc);
    chk("accept_known", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 30; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick(1'b0, 32'd0, 1'b1, 1'b0, 34'd0, 34'd0, acc);
    end
    chk("drain_empty", q0.size() + q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic pending;
    logic v;
    logic [31:0] a;
    logic [31:0] held_z;
    int idx;
    logic [31:0] specials [8];
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'hCF00_0000, 32'h4F00_0000, 32'hBF00_0000};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {out_valid0, out_valid1}, 2'b00);
    chk("rst_out_z", {out_z0, out_z1}, 64'd0);
    chk("rst_flags", {out_invalid0, out_inexact0, out_invalid1, out_inexact1}, 4'b0000);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {in_ready0, in_ready1}, 2'b11);

    // 1.0 with latency check
    send_known(32'h3F80_0000, {32'h0000_0001, 2'b00}, {32'h0000_0001, 2'b00});
    for (int c = 1; c <= 3; c++) begin
      tick(1'b0, 32'd0, 1'b1, 1'b0, 34'd0, 34'd0, acc);
      chk($sformatf("latency_c%0d", c), smp_ov, (c == 3));
    end
    drain();

    // -2.5, 3.5, 0.5, smallest denormal, back to back
    send_known(32'hC020_0000, {32'hFFFF_FFFE, 2'b01}, {32'hFFFF_FFFE, 2'b01});
    send_known(32'h4060_0000, {32'h0000_0003, 2'b01}, {32'h0000_0004, 2'b01});
    send_known(32'h3F00_0000, {32'h0000_0000, 2'b01}, {32'h0000_0000, 2'b01});
    send_known(32'h0000_0001, {32'h0000_0000, 2'b01}, {32'h0000_0000, 2'b01});
    // range edges
    send_known(32'h4F00_0000, {32'h7FFF_FFFF, 2'b10}, {32'h7FFF_FFFF, 2'b10});
    send_known(32'hCF00_0000, {32'h8000_0000, 2'b00}, {32'h8000_0000, 2'b00});
    send_known(32'h7F80_0000, {32'h7FFF_FFFF, 2'b10}, {32'h7FFF_FFFF, 2'b10});
    send_known(32'hFF80_0000, {32'h8000_0000, 2'b10}, {32'h8000_0000, 2'b10});
    send_known(32'h7FC0_0000, {32'h8000_0000, 2'b10}, {32'h8000_0000, 2'b10});
    send_known(32'h4EFF_FFFF, {32'h7FFF_FF80, 2'b00}, {32'h7FFF_FF80, 2'b00});
    send_known(32'h8000_0000, {32'h0000_0000, 2'b00}, {32'h0000_0000, 2'b00});
    drain();

    // Backpressure: out_ready low for cycles 4..7 of a six-value stream
    idx = 0;
    held_z = 32'd0;
    for (int c = 0; c < 16; c++) begin
      tick(idx < 6, 32'h3F80_0000 + (idx << 23), !(c >= 4 && c <= 7), 1'b0, 34'd0, 34'd0, acc);
      chk($sformatf("bp_in_ready_c%0d", c), smp_rdy, !(c >= 4 && c <= 7));
      if (c == 4) held_z = smp_z;
      if (c >= 5 && c <= 7) chk($sformatf("bp_hold_c%0d", c), smp_z, held_z);
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 6);
    drain();

    // Reset with three values in flight
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h4040_0000 + (i << 20), 1'b1, 1'b0, 34'd0, 34'd0, acc);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", {out_valid0, out_valid1}, 2'b00);
    chk("midrst_out_z", {out_z0, out_z1}, 64'd0);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1, 32'hC0A0_0000 + (i << 21), 1'b1, 1'b0, 34'd0, 34'd0, acc);
    drain();

    // Randomized traffic with random bubbles and backpressure
    pending = 1'b0;
    v = 1'b0;
    a = 32'd0;
    for (int n = 0; n < 600; n++) begin
      if (!pending) begin
        v = ($urandom_range(0, 9) < 8);
        case ($urandom_range(0, 4))
          0:       a = $urandom;
          1, 2:    a = {1'($urandom), 8'($urandom_range(100, 160)), 23'($urandom)};
          3:       a = specials[$urandom_range(0, 7)];
          default: a = {1'($urandom), 8'($urandom_range(125, 135)), 2'($urandom), 21'd0};
        endcase
      end
      tick(v, a, ($urandom_range(0, 3) != 0), 1'b0, 34'd0, 34'd0, acc);
      pending = v & !acc;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
